// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_MULDIV = 1'b1
  } ctrl_state_e;

  localparam int unsigned DEFAULT_MULDIV_LATENCY = 4;

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating enable counter; counts cycles with en_i high, holds at all-ones.
module stall_perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: increment when enabled, stop at all-ones.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller for the 5-stage pipeline. Merges load-use stalls, multi-cycle
// MULT/DIV occupancy of EX and taken-branch flushes into pipeline enables and strobes.
// Optional macro STALL_PERF_EN adds a saturating stall-cycle counter on stall_cycles.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
  parameter int unsigned CNT_WIDTH      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_hazard,
  input  logic                 muldiv_start,
  input  logic                 branch_taken,
  output logic                 PCWrite,
  output logic                 Write_IFID,
  output logic                 Write_IDEX,
  output logic                 bubble_IDEX,
  output logic                 bubble_EXMEM,
  output logic                 flush_IFID,
  output logic                 flush_IDEX,
  output logic                 muldiv_done,
  output logic                 muldiv_abort,
  output logic [BIT_WIDTH-1:0] stall_cycles
);

  if (MULDIV_LATENCY < 2) begin : g_bad_latency
    $error("MULDIV_LATENCY must be at least 2");
  end
  if ((MULDIV_LATENCY - 2) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt_width
    $error("CNT_WIDTH too narrow for MULDIV_LATENCY-2");
  end

  // Start cycle plus CntLoad+1 further cycles gives MULDIV_LATENCY cycles in EX.
  localparam logic [CNT_WIDTH-1:0] CntLoad = CNT_WIDTH'(MULDIV_LATENCY - 2);

  ctrl_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next state, counter and all control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PCWrite      = 1'b1;
    Write_IFID   = 1'b1;
    Write_IDEX   = 1'b1;
    bubble_IDEX  = 1'b0;
    bubble_EXMEM = 1'b0;
    flush_IFID   = 1'b0;
    flush_IDEX   = 1'b0;
    muldiv_done  = 1'b0;
    muldiv_abort = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_RUN: begin
          if (branch_taken) begin
            // Younger instructions are killed, so their hazards are irrelevant.
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (muldiv_start) begin
            PCWrite      = 1'b0;
            Write_IFID   = 1'b0;
            Write_IDEX   = 1'b0;
            bubble_EXMEM = 1'b1;
            cnt_d        = CntLoad;
            state_d      = S_MULDIV;
          end else if (load_use_hazard) begin
            PCWrite     = 1'b0;
            Write_IFID  = 1'b0;
            bubble_IDEX = 1'b1;
          end
        end
        S_MULDIV: begin
          if (branch_taken) begin
            flush_IFID   = 1'b1;
            flush_IDEX   = 1'b1;
            muldiv_abort = 1'b1;
            cnt_d        = '0;
            state_d      = S_RUN;
          end else if (cnt_q != '0) begin
            PCWrite      = 1'b0;
            Write_IFID   = 1'b0;
            Write_IDEX   = 1'b0;
            bubble_EXMEM = 1'b1;
            cnt_d        = cnt_q - CNT_WIDTH'(1);
          end else begin
            // Result leaves EX with default enables; the held instruction advances.
            muldiv_done = 1'b1;
            state_d     = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_EN
  stall_perf_counter #(
    .Width(BIT_WIDTH)
  ) u_stall_perf_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (!PCWrite && !rst),
    .count_o(stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a driver computes expected outputs from a
// cycle-count model and queues them; a monitor pops and compares on the falling edge.
module tb_pipeline_stall_controller;

  localparam int unsigned Lat = 4;
  localparam int unsigned Bw  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use_hazard = 1'b0;
  logic muldiv_start = 1'b0;
  logic branch_taken = 1'b0;
  logic PCWrite, Write_IFID, Write_IDEX, bubble_IDEX, bubble_EXMEM;
  logic flush_IFID, flush_IDEX, muldiv_done, muldiv_abort;
  logic [Bw-1:0] stall_cycles;

  pipeline_stall_controller #(
    .BIT_WIDTH     (Bw),
    .MULDIV_LATENCY(Lat),
    .CNT_WIDTH     (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_hazard(load_use_hazard),
    .muldiv_start   (muldiv_start),
    .branch_taken   (branch_taken),
    .PCWrite        (PCWrite),
    .Write_IFID     (Write_IFID),
    .Write_IDEX     (Write_IDEX),
    .bubble_IDEX    (bubble_IDEX),
    .bubble_EXMEM   (bubble_EXMEM),
    .flush_IFID     (flush_IFID),
    .flush_IDEX     (flush_IDEX),
    .muldiv_done    (muldiv_done),
    .muldiv_abort   (muldiv_abort),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  // Flag order: PCWrite, Write_IFID, Write_IDEX, bubble_IDEX, bubble_EXMEM,
  // flush_IFID, flush_IDEX, muldiv_done, muldiv_abort.
  typedef struct packed {
    logic [8:0]    flags;
    logic [Bw-1:0] cnt;
    logic          chk_cnt;
    int unsigned   cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: number of further EX cycles the MULT/DIV still needs (0 = none).
  int unsigned ex_left = 0;
  longint unsigned stalls = 0;
  bit cnt_known = 1'b0;
  int unsigned cyc = 0;

  task automatic step(input logic r, input logic l, input logic m, input logic b);
    exp_t e;
    logic [8:0] f;
    @(posedge clk);
    #1;
    rst = r; load_use_hazard = l; muldiv_start = m; branch_taken = b;
    f = 9'b111_000000;
    if (r) begin
      ex_left = 0;
    end else if (ex_left == 0) begin
      if (b) f = 9'b111_00_11_00;
      else if (m) begin
        f = 9'b000_01_00_00;
        ex_left = Lat - 1;
      end else if (l) f = 9'b001_10_00_00;
    end else begin
      if (b) begin
        f = 9'b111_00_11_01;
        ex_left = 0;
      end else if (ex_left == 1) begin
        f = 9'b111_00_00_10;
        ex_left = 0;
      end else begin
        f = 9'b000_01_00_00;
        ex_left = ex_left - 1;
      end
    end
`ifdef STALL_PERF_EN
    e.cnt = (stalls > 64'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : stalls[Bw-1:0];
`else
    e.cnt = '0;
`endif
    e.chk_cnt = cnt_known;
    e.flags = f;
    e.cyc = cyc;
    cyc++;
    if (r) begin
      stalls = 0;
      cnt_known = 1'b1;
    end else if (!f[8]) begin
      stalls++;
    end
    q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare against the queued expectation.
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {PCWrite, Write_IFID, Write_IDEX, bubble_IDEX, bubble_EXMEM,
               flush_IFID, flush_IDEX, muldiv_done, muldiv_abort};
        checks++;
        if (got !== e.flags) begin
          failures++;
          $display("FAIL ctrl_flags cycle %0d: got %b expected %b", e.cyc, got, e.flags);
        end
        if (e.chk_cnt) begin
          checks++;
          if (stall_cycles !== e.cnt) begin
            failures++;
            $display("FAIL stall_cycles cycle %0d: got %0d expected %0d",
                     e.cyc, stall_cycles, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    // Reset with every input high.
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    // Single load-use bubble then defaults.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // One MULT/DIV held for its full latency.
    repeat (Lat) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // MULT/DIV aborted by a branch in its second cycle.
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    // Branch beats load-use.
    step(0, 1, 0, 1);
    // Two back-to-back MULT/DIVs.
    repeat (2 * Lat) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Simultaneous load-use and MULT/DIV start: MULT/DIV wins.
    step(0, 1, 1, 0);
    repeat (Lat) step(0, 0, 0, 0);
    // Reset mid-MULT/DIV: no abort, back to defaults.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end
    step(0, 0, 0, 0);
    // Drain with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
